// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared data-cache tag type and flush state encoding
package std_cache_pkg;

  // Tag field sized for the widest supported physical address; a given cache
  // configuration only populates the low PLEN-IDX_W-OFF_W bits.
  localparam int unsigned DCACHE_TAG_MAX_W = 56;

  typedef struct packed {
    logic                        valid;
    logic                        dirty;
    logic [DCACHE_TAG_MAX_W-1:0] tag;
  } dcache_tag_t;

  typedef enum logic [2:0] {
    FL_INIT,
    FL_IDLE,
    FL_READ,
    FL_CHECK,
    FL_WB_REQ,
    FL_WB_WAIT,
    FL_INV,
    FL_ACK
  } flush_state_e;

endpackage

// File: rtl/dcache_flush_unit_if.sv
// rtl/dcache_flush_unit_if.sv - tag-read, write-back and invalidate channels of the flush unit
interface dcache_flush_unit_if #(
  parameter int unsigned PLEN     = 56,
  parameter int unsigned NUM_SETS = 256,
  parameter int unsigned NUM_WAYS = 8
);
  import std_cache_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic             tag_req;
  logic             tag_gnt;
  logic [IDX_W-1:0] tag_index;
  logic [WAY_W-1:0] tag_way;
  dcache_tag_t      tag_rdata;

  logic             wb_req;
  logic             wb_gnt;
  logic             wb_done;
  logic [PLEN-1:0]  wb_addr;
  logic [WAY_W-1:0] wb_way;

  logic             inv_req;
  logic             inv_gnt;
  logic [IDX_W-1:0] inv_index;
  logic [WAY_W-1:0] inv_way;

  // Flush unit side: issues all requests.
  modport master (
    output tag_req, tag_index, tag_way,
    input  tag_gnt, tag_rdata,
    output wb_req, wb_addr, wb_way,
    input  wb_gnt, wb_done,
    output inv_req, inv_index, inv_way,
    input  inv_gnt
  );

  // Cache side: tag array, write-back path and tag write port.
  modport slave (
    input  tag_req, tag_index, tag_way,
    output tag_gnt, tag_rdata,
    input  wb_req, wb_addr, wb_way,
    output wb_gnt, wb_done,
    input  inv_req, inv_index, inv_way,
    output inv_gnt
  );

endinterface

// File: rtl/flush_line_iter.sv
// rtl/flush_line_iter.sv - set/way sweep counter, way inner and set outer
module flush_line_iter #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned WAY_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [IDX_W-1:0] set_o,
  output logic [WAY_W-1:0] way_o,
  output logic             last_o
);

  localparam int unsigned CNT_W = IDX_W + WAY_W;

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Way bits sit below set bits, so a plain increment walks every way of a set first.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign way_o  = cnt_q[WAY_W-1:0];
  assign set_o  = cnt_q[CNT_W-1:WAY_W];
  assign last_o = &cnt_q;

endmodule

// File: rtl/dcache_flush_unit.sv
// rtl/dcache_flush_unit.sv - data-cache flush responder; DCACHE_INIT_SWEEP_EN adds the post-reset invalidate sweep
module dcache_flush_unit
  import std_cache_pkg::*;
#(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned NUM_SETS   = 256,
  parameter int unsigned NUM_WAYS   = 8,
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  input  logic                cache_init_ni,
  dcache_flush_unit_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);

  flush_state_e state_d, state_q;
  flush_state_e reset_state;
  logic tag_req_d, tag_req_q;
  logic wb_req_d, wb_req_q;
  logic inv_req_d, inv_req_q;
  logic ack_d, ack_q;
  logic armed_d, armed_q;
  logic [DCACHE_TAG_MAX_W-1:0] tag_d, tag_q;

  logic             iter_clr, iter_adv, iter_last;
  logic             line_done;
  logic [IDX_W-1:0] iter_set;
  logic [WAY_W-1:0] iter_way;

`ifdef DCACHE_INIT_SWEEP_EN
  // cache_init_ni is a strap held steady across reset; it picks the state we wake in.
  assign reset_state = cache_init_ni ? FL_IDLE : FL_INIT;
`else
  logic init_unused;
  assign init_unused = cache_init_ni;
  assign reset_state = FL_IDLE;
`endif

  flush_line_iter #(
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_iter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (iter_clr),
    .adv_i  (iter_adv),
    .set_o  (iter_set),
    .way_o  (iter_way),
    .last_o (iter_last)
  );

  // Next state and next registered outputs; requests are held until granted.
  always_comb begin
    state_d   = state_q;
    tag_req_d = 1'b0;
    wb_req_d  = 1'b0;
    inv_req_d = 1'b0;
    ack_d     = 1'b0;
    armed_d   = armed_q;
    tag_d     = tag_q;
    iter_clr  = 1'b0;
    iter_adv  = 1'b0;
    line_done = 1'b0;
    case (state_q)
`ifdef DCACHE_INIT_SWEEP_EN
      FL_INIT: begin
        inv_req_d = 1'b1;
        if (inv_req_q && bus.inv_gnt) begin
          if (iter_last) begin
            inv_req_d = 1'b0;
            state_d   = FL_IDLE;
          end else begin
            iter_adv = 1'b1;
          end
        end
      end
`endif
      FL_IDLE: begin
        // A request still high right after ack must drop once before it counts again.
        if (!flush_i) armed_d = 1'b1;
        if (flush_i && armed_q) begin
          iter_clr  = 1'b1;
          tag_req_d = 1'b1;
          state_d   = FL_READ;
        end
      end
      FL_READ: begin
        if (bus.tag_gnt) state_d = FL_CHECK;
        else             tag_req_d = 1'b1;
      end
      FL_CHECK: begin
        tag_d = bus.tag_rdata.tag;
        if (!bus.tag_rdata.valid) begin
          line_done = 1'b1;
        end else if (bus.tag_rdata.dirty) begin
          wb_req_d = 1'b1;
          state_d  = FL_WB_REQ;
        end else begin
          inv_req_d = 1'b1;
          state_d   = FL_INV;
        end
      end
      FL_WB_REQ: begin
        if (bus.wb_gnt) state_d = FL_WB_WAIT;
        else            wb_req_d = 1'b1;
      end
      FL_WB_WAIT: begin
        if (bus.wb_done) begin
          inv_req_d = 1'b1;
          state_d   = FL_INV;
        end
      end
      FL_INV: begin
        if (bus.inv_gnt) line_done = 1'b1;
        else             inv_req_d = 1'b1;
      end
      FL_ACK: begin
        armed_d = 1'b0;
        state_d = FL_IDLE;
      end
      default: state_d = FL_IDLE;
    endcase
    if (line_done) begin
      if (iter_last) begin
        ack_d   = 1'b1;
        state_d = FL_ACK;
      end else begin
        iter_adv  = 1'b1;
        tag_req_d = 1'b1;
        state_d   = FL_READ;
      end
    end
  end

  // State and registered outputs; reset drops every request immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= reset_state;
      tag_req_q <= 1'b0;
      wb_req_q  <= 1'b0;
      inv_req_q <= 1'b0;
      ack_q     <= 1'b0;
      armed_q   <= 1'b1;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      tag_req_q <= tag_req_d;
      wb_req_q  <= wb_req_d;
      inv_req_q <= inv_req_d;
      ack_q     <= ack_d;
      armed_q   <= armed_d;
      tag_q     <= tag_d;
    end
  end

  assign busy_o      = (state_q != FL_IDLE);
  assign flush_ack_o = ack_q;

  assign bus.tag_req   = tag_req_q;
  assign bus.tag_index = iter_set;
  assign bus.tag_way   = iter_way;
  assign bus.wb_req    = wb_req_q;
  // Truncation keeps the populated tag bits above the set index and line offset.
  assign bus.wb_addr   = PLEN'({tag_q, iter_set, {OFF_W{1'b0}}});
  assign bus.wb_way    = iter_way;
  assign bus.inv_req   = inv_req_q;
  assign bus.inv_index = iter_set;
  assign bus.inv_way   = iter_way;

endmodule

// File: doc/dcache_flush_unit.md
# dcache_flush_unit

Responder side of the data-cache flush handshake driven by the flush controller. On a held flush request it sweeps every set/way of the write-back data cache, writes dirty lines back to memory, invalidates valid lines, then returns a single-cycle acknowledge. It sits inside the data cache between the tag array, the write-back path and the controller's `flush_dcache_o`/`flush_dcache_ack_i` pair. Optionally it also performs the post-(micro)reset invalidate sweep.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low (`clk_i`, `rst_ni`).
- `PLEN`, 56: physical address width.
- `NUM_SETS`, 256: sets, power of two; `IDX_W = $clog2(NUM_SETS)`.
- `NUM_WAYS`, 8: ways, power of two, ≥2; `WAY_W = $clog2(NUM_WAYS)`.
- `LINE_BYTES`, 16: line size; `OFF_W = $clog2(LINE_BYTES)`; `TAG_W = PLEN-IDX_W-OFF_W`.
- `clk_i  in  1  clock`
- `rst_ni  in  1  async active-low reset`
- `flush_i  in  1  flush request, level, held until ack`
- `flush_ack_o  out  1  one-cycle flush-done pulse`
- `busy_o  out  1  unit not IDLE`
- `cache_init_ni  in  1  low = perform init sweep after reset (macro only)`
- `tag_req_o / tag_gnt_i  out/in  1/1  tag read handshake`
- `tag_index_o  out  IDX_W  set`; `tag_way_o  out  WAY_W  way`
- `tag_rdata_i  in  dcache_tag_t  {valid, dirty, tag[TAG_W]}; valid the cycle after req&gnt`
- `wb_req_o / wb_gnt_i / wb_done_i  out/in/in  1  write-back request, accept, completion pulse`
- `wb_addr_o  out  PLEN  {tag, index, OFF_W'0}`; `wb_way_o  out  WAY_W`
- `inv_req_o / inv_gnt_i  out/in  1/1  invalidate (valid=0, dirty=0) write`
- `inv_index_o  out  IDX_W`; `inv_way_o  out  WAY_W`

## Operation
- States: INIT, IDLE, READ, CHECK, WB_REQ, WB_WAIT, INV, ACK.
- Set/way iterator: way inner, set outer, starts at {0,0}; "last" = set NUM_SETS-1, way NUM_WAYS-1.
- IDLE: if `flush_i` and armed → READ, iterator cleared.
- READ: `tag_req_o`=1 until `tag_gnt_i`; then → CHECK.
- CHECK: latch `tag_rdata_i`. Invalid → advance; valid&dirty → WB_REQ; valid&clean → INV.
- WB_REQ: `wb_req_o`=1, address from latched tag, until `wb_gnt_i` → WB_WAIT. WB_WAIT: on `wb_done_i` → INV.
- INV: `inv_req_o`=1 until `inv_gnt_i` → advance.
- Advance: if last → ACK, else increment and → READ.
- ACK: `flush_ack_o`=1 one cycle → IDLE, armed cleared.
- Armed: set when `flush_i` is sampled low in IDLE; prevents restarting on the controller's registered request that is still high the cycle after ack.
- Requests (`tag_req_o`, `wb_req_o`, `inv_req_o`) are mutually exclusive. Their address/way outputs are stable while the request is high.
- `flush_i` dropping mid-sweep is ignored; the sweep completes and acks.
- Reset mid-sweep: all state discarded, no ack. No handshake is left pending on the unit's side.

## Timing
- Reset values: all request outputs 0, `flush_ack_o`=0, `busy_o`=1 if entering INIT else 0, iterator 0, armed=1.
- Zero-wait grants: invalid line 2 cycles (READ, CHECK); clean valid line 3 cycles; dirty line 4 cycles + `wb_done_i` latency.
- `flush_ack_o` is high exactly 1 cycle after the last line's INV grant or the last line's CHECK-invalid.
- Minimum flush of an all-invalid cache: 2·NUM_SETS·NUM_WAYS + 2 cycles from request sample to ack.
- `busy_o` = state != IDLE (combinational from state register).

## Configuration
- `DCACHE_INIT_SWEEP_EN` defined:
  - On reset release with `cache_init_ni`=0, enter INIT. Issue `inv_req_o` for every set/way in iterator order, 1 line per grant, no reads, no write-backs, no ack. Then → IDLE.
  - With `cache_init_ni`=1, enter IDLE directly.
- Undefined: INIT state is absent, `cache_init_ni` is ignored, and reset enters IDLE.

## Structure
- `dcache_tag_t` struct and the `flush_state_e` enum live in `std_cache_pkg`. Derived widths are local parameters.
- One sub-module: `flush_line_iter` (set/way counter with clear, advance, `last_o`), used by both the flush sweep and the INIT sweep.

## Test plan
Bench uses NUM_SETS=4, NUM_WAYS=2, always-grant unless stated.
- All lines invalid, `flush_i` held → no wb/inv requests; ack pulse 18 cycles after request sample; `busy_o` high throughout.
- Set 2 way 1 dirty with tag 0x5, `wb_done_i` 3 cycles after grant → one `wb_addr_o`=0x5<<6 | 2<<4 = 0x160, then inv (2,1); ack after last line.
- `flush_i` held for 2 cycles after ack → no second sweep; drop for 1 cycle then raise → new sweep starts.
- `tag_gnt_i` and `inv_gnt_i` stalled 5 cycles each → requests and index/way held stable; line count unchanged.
- Reset asserted during WB_WAIT → all requests 0 immediately; no ack. After release, a fresh flush sweeps from {0,0}.
- With `DCACHE_INIT_SWEEP_EN` and `cache_init_ni`=0 → 8 invalidates in order (0,0)…(3,1); no tag reads; then IDLE with `busy_o`=0.
